// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, opcode classification helpers and
// the issue-sequencer FSM state type.
package alu_pkg;

  localparam int unsigned AluDw   = 8;
  localparam int unsigned AluOpw  = 4;
  localparam int unsigned AluCntw = 4;

  typedef enum logic [AluOpw-1:0] {
    OpAdd  = 4'd0,
    OpXor  = 4'd1,
    OpOrr  = 4'd2,
    OpBne  = 4'd5,
    OpSll  = 4'd6,
    OpSrl  = 4'd7,
    OpAnd  = 4'd8,
    OpRxor = 4'd9,
    OpSub  = 4'd12,
    OpBeq  = 4'd13
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_t;

  function automatic logic is_legal_op(logic [AluOpw-1:0] op);
    case (op_t'(op))
      OpAdd, OpXor, OpOrr, OpBne, OpSll,
      OpSrl, OpAnd, OpRxor, OpSub, OpBeq: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch_op(logic [AluOpw-1:0] op);
    return (op_t'(op) == OpBne) || (op_t'(op) == OpBeq);
  endfunction

endpackage

// File: rtl/alu_rep_counter.sv
// Iteration counter for the issue sequencer: load, decrement, and flag the
// final iteration.
module alu_rep_counter
  import alu_pkg::*;
#(
  parameter int unsigned CNTW = AluCntw
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            last
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNTW'(1));

endmodule

// File: rtl/alu_issue_sequencer.sv
// Accepts ALU requests, drives the external ALU from registers, feeds the
// result back into operand A for the repeat count, and returns the final result.
module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DW   = AluDw,
  parameter int unsigned OPW  = AluOpw,
  parameter int unsigned CNTW = AluCntw
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_op,
  input  logic [DW-1:0]   req_a,
  input  logic [DW-1:0]   req_b,
  input  logic [CNTW-1:0] req_reps,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  output logic            alu_en,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_jump,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic            res_branch,
  output logic            res_illegal
);

  state_t         state_q, state_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic           alu_en_q, alu_en_d;
  logic           res_valid_q, res_valid_d;
  logic [DW-1:0]  res_data_q, res_data_d;
  logic           res_branch_q, res_branch_d;
  logic           res_illegal_q, res_illegal_d;

  logic            cnt_load, cnt_dec, cnt_last;
  logic [CNTW-1:0] cnt_load_val, cnt_val;

  // Branches resolve in a single pass; a zero repeat count means one pass.
  always_comb begin
    if (is_branch_op(req_op) || (req_reps == '0)) begin
      cnt_load_val = CNTW'(1);
    end else begin
      cnt_load_val = req_reps;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_en_d      = alu_en_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_branch_d  = res_branch_q;
    res_illegal_d = res_illegal_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    req_ready     = (state_q == StIdle);

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (is_legal_op(req_op)) begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_op_d = req_op;
            alu_en_d = 1'b1;
            cnt_load = 1'b1;
            state_d  = StExec;
          end else begin
            res_data_d    = '0;
            res_branch_d  = 1'b0;
            res_illegal_d = 1'b1;
            res_valid_d   = 1'b1;
            state_d       = StDone;
          end
        end
      end
      StExec: begin
        if (cnt_last) begin
          res_data_d    = alu_out;
          res_branch_d  = alu_jump;
          res_illegal_d = 1'b0;
          res_valid_d   = 1'b1;
          alu_en_d      = 1'b0;
          state_d       = StDone;
        end else begin
          alu_a_d = alu_out;
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_en_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_branch_q  <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_en_q      <= alu_en_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_branch_q  <= res_branch_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  alu_rep_counter #(
    .CNTW(CNTW)
  ) u_rep_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .last     (cnt_last)
  );

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_en      = alu_en_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_branch  = res_branch_q;
  assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: a behavioural ALU drives alu_out/alu_jump and a
// loop-based reference predicts every issue step, result and handshake.
module tb_alu_issue_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       req_valid, req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a, req_b;
  logic [3:0] req_reps;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic       alu_en;
  logic [7:0] alu_out;
  logic       alu_jump;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_branch, res_illegal;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] last_a, last_b;
  logic [3:0] last_op;

  always #5 Clk = ~Clk;

  alu_issue_sequencer u_dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_reps    (req_reps),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_en      (alu_en),
    .alu_out     (alu_out),
    .alu_jump    (alu_jump),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_branch  (res_branch),
    .res_illegal (res_illegal)
  );

  // Returns {jump, result}.
  function automatic logic [8:0] alu_fn(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a ^ b};
      4'd2:    return {1'b0, a | b};
      4'd5:    return {a != b, 7'd0, a != b};
      4'd6:    return {1'b0, a << b[2:0]};
      4'd7:    return {1'b0, a >> b[2:0]};
      4'd8:    return {1'b0, a & b};
      4'd9:    return {1'b0, 7'd0, ^a};
      4'd12:   return {1'b0, a - b};
      4'd13:   return {a == b, 7'd0, a == b};
      default: return 9'd0;
    endcase
  endfunction

  always_comb {alu_jump, alu_out} = alu_fn(alu_op, alu_a, alu_b);

  function automatic bit legal_ref(logic [3:0] op);
    int legal_codes[$] = '{0, 1, 2, 5, 6, 7, 8, 9, 12, 13};
    foreach (legal_codes[i]) if (int'(op) == legal_codes[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    last_a = 8'd0;
    last_b = 8'd0;
    last_op = 4'd0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check_eq({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check_eq({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check_eq({tag, "_alu_en"}, 32'(alu_en), 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_res_data"}, 32'(res_data), 32'd0);
    check_eq({tag, "_res_branch"}, 32'(res_branch), 32'd0);
    check_eq({tag, "_res_illegal"}, 32'(res_illegal), 32'd0);
  endtask

  task automatic check_done(input logic [7:0] d, input logic br, input logic ill);
    check_eq("done_valid", 32'(res_valid), 32'd1);
    check_eq("done_data", 32'(res_data), 32'(d));
    check_eq("done_branch", 32'(res_branch), 32'(br));
    check_eq("done_illegal", 32'(res_illegal), 32'(ill));
    check_eq("done_req_ready", 32'(req_ready), 32'd0);
    check_eq("done_alu_en", 32'(alu_en), 32'd0);
    check_eq("done_alu_a", 32'(alu_a), 32'(last_a));
    check_eq("done_alu_b", 32'(alu_b), 32'(last_b));
    check_eq("done_alu_op", 32'(alu_op), 32'(last_op));
  endtask

  // Entry and exit: #1 after a rising edge with the sequencer idle.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] reps, input int hold);
    bit         legal = legal_ref(op);
    int         eff = (op == 4'd5 || op == 4'd13 || reps == 4'd0) ? 1 : int'(reps);
    logic [7:0] cur = a;
    logic       jmp = 1'b0;
    logic [8:0] r;
    logic [7:0] exp_d;
    logic       exp_br, exp_ill;

    check_eq("idle_req_ready", 32'(req_ready), 32'd1);
    req_op = op; req_a = a; req_b = b; req_reps = reps; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    req_reps = 4'($urandom);

    if (legal) begin
      for (int k = 0; k < eff; k++) begin
        check_eq("exec_alu_en", 32'(alu_en), 32'd1);
        check_eq("exec_alu_a", 32'(alu_a), 32'(cur));
        check_eq("exec_alu_b", 32'(alu_b), 32'(b));
        check_eq("exec_alu_op", 32'(alu_op), 32'(op));
        check_eq("exec_res_valid", 32'(res_valid), 32'd0);
        check_eq("exec_req_ready", 32'(req_ready), 32'd0);
        r = alu_fn(op, cur, b);
        last_a = cur;
        cur = r[7:0];
        jmp = r[8];
        step();
      end
      last_b = b;
      last_op = op;
      exp_d = cur; exp_br = jmp; exp_ill = 1'b0;
    end else begin
      exp_d = 8'd0; exp_br = 1'b0; exp_ill = 1'b1;
    end
    check_done(exp_d, exp_br, exp_ill);

    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom);
      req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
      req_reps = 4'($urandom);
      step();
      check_done(exp_d, exp_br, exp_ill);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_eq("release_res_valid", 32'(res_valid), 32'd0);
    check_eq("release_req_ready", 32'(req_ready), 32'd1);
    check_eq("release_alu_en", 32'(alu_en), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_op = 4'd0; req_a = 8'd0; req_b = 8'd0; req_reps = 4'd0;
    do_reset();
    check_idle_zero("reset");

    run_op(4'd0, 8'h01, 8'h01, 4'd1, 0);   // ADD -> 0x02
    run_op(4'd6, 8'h01, 8'h01, 4'd3, 0);   // SLL x3 -> 0x08
    run_op(4'd13, 8'h51, 8'h51, 4'd5, 1);  // BEQ forced single pass
    run_op(4'd5, 8'h51, 8'h44, 4'd7, 0);   // BNE
    run_op(4'd3, 8'hAA, 8'h55, 4'd2, 2);   // illegal opcode
    run_op(4'd1, 8'h51, 8'h07, 4'd1, 4);   // XOR under backpressure -> 0x56
    run_op(4'd12, 8'h00, 8'h01, 4'd0, 0);  // SUB wraps, reps=0 acts as 1
    run_op(4'd0, 8'hF0, 8'h11, 4'd15, 1);  // max count, wrapping accumulate

    // Reset in the third EXEC cycle discards the operation.
    req_op = 4'd0; req_a = 8'h10; req_b = 8'h01; req_reps = 4'd8; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_eq("mid_exec_alu_en", 32'(alu_en), 32'd1);
    step();
    step();
    check_eq("mid_exec_alu_a", 32'(alu_a), 32'h12);
    Reset = 1'b1;
    step();
    check_idle_zero("mid_reset");
    Reset = 1'b0;
    last_a = 8'd0; last_b = 8'd0; last_op = 4'd0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("post_reset_no_valid", 32'(res_valid), 32'd0);
      check_eq("post_reset_no_en", 32'(alu_en), 32'd0);
    end
    res_ready = 1'b0;

    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
